// File: rtl/ld_operand_fetch_pkg.sv
// Shared definitions for the MIX load operand-fetch slice: word/field layout,
// memory size and the fetch FSM encoding.
package ld_operand_fetch_pkg;

   localparam int MEM_WORDS_DEF = 4000;
   localparam int ADDR_W        = 12;
   localparam int FIELD_W       = 6;

   // MIX word: sign bit above five 6-bit bytes, byte 1 most significant.
   localparam int BYTE_W    = 6;
   localparam int NUM_BYTES = 5;
   localparam int SIGN_BIT  = BYTE_W * NUM_BYTES;
   localparam int WORD_W    = SIGN_BIT + 1;

   // F = 8L + R
   localparam int FIELD_R_LSB = 0;
   localparam int FIELD_R_MSB = 2;
   localparam int FIELD_L_LSB = 3;
   localparam int FIELD_L_MSB = 5;
   localparam int MAX_R       = NUM_BYTES;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_ISSUE,
      S_HOLD,
      S_DONE
   } state_e;

endpackage

// File: rtl/ld_operand_fetch_field_check.sv
// Combinational validity check of an effective address and an L:R field spec;
// shared by the load, store and compare fetch stages.
module field_check
   import ld_operand_fetch_pkg::*;
#(
   parameter int MEM_WORDS = MEM_WORDS_DEF
) (
   input  logic [ADDR_W-1:0]  addr_i,
   input  logic [FIELD_W-1:0] field_i,
   output logic               valid_o
);

   typedef logic [ADDR_W:0] addrExt_t;

   // One extra bit so a MEM_WORDS of 4096 still compares correctly.
   localparam addrExt_t AddrLimit = addrExt_t'(MEM_WORDS);

   logic [2:0] fieldR;
   logic [2:0] fieldL;

   assign fieldR  = field_i[FIELD_R_MSB:FIELD_R_LSB];
   assign fieldL  = field_i[FIELD_L_MSB:FIELD_L_LSB];
   assign valid_o = ({1'b0, addr_i} < AddrLimit) &&
                    (fieldR <= 3'(MAX_R)) &&
                    (fieldL <= fieldR);

endmodule

// File: rtl/ld_operand_fetch.sv
// Operand-fetch stage for LDA/LDX/LD1-LD6 (and negated forms): validates M and F,
// reads the memory word, then hands it to the LD field-extraction unit.
module ld_operand_fetch
   import ld_operand_fetch_pkg::*;
#(
   parameter int MEM_WORDS   = MEM_WORDS_DEF,
   parameter int MEM_LATENCY = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ADDR_W-1:0]  address,
   input  logic [FIELD_W-1:0] field,
   input  logic               neg,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_re,
   input  logic [WORD_W-1:0]  mem_data,
   output logic               ld_start,
   output logic [WORD_W-1:0]  ld_in,
   output logic [FIELD_W-1:0] ld_field,
   output logic               ld_neg,
   input  logic               ld_stop,
   output logic               stop,
   output logic               fault
);

   localparam logic [1:0] LatLoad = 2'(MEM_LATENCY - 1);

   state_e               state_q;
   logic [1:0]           latCnt_q;
   logic [FIELD_W-1:0]   capField_q;
   logic                 capNeg_q;
   logic [ADDR_W-1:0]    memAddr_q;
   logic                 memRe_q;
   logic                 ldStart_q;
   logic [WORD_W-1:0]    ldIn_q;
   logic [FIELD_W-1:0]   ldField_q;
   logic                 ldNeg_q;
   logic                 stop_q;
   logic                 fault_q;
   logic                 reqValid;

   // Validity is judged on the live request so IDLE can branch in the same edge it captures.
   field_check #(
      .MEM_WORDS (MEM_WORDS)
   ) u_fieldCheck (
      .addr_i  (address),
      .field_i (field),
      .valid_o (reqValid)
   );

   // Fetch sequencer; every output is a register written here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         latCnt_q   <= '0;
         capField_q <= '0;
         capNeg_q   <= 1'b0;
         memAddr_q  <= '0;
         memRe_q    <= 1'b0;
         ldStart_q  <= 1'b0;
         ldIn_q     <= '0;
         ldField_q  <= '0;
         ldNeg_q    <= 1'b0;
         stop_q     <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  capField_q <= field;
                  capNeg_q   <= neg;
                  if (reqValid) begin
                     memAddr_q <= address;
                     memRe_q   <= 1'b1;
                     state_q   <= S_READ;
                  end else begin
                     stop_q  <= 1'b1;
                     fault_q <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
            S_READ: begin
               memRe_q  <= 1'b0;
               latCnt_q <= LatLoad;
               state_q  <= S_WAIT;
            end
            S_WAIT: begin
               // ld_* only change here, so they stay stable until the next valid fetch.
               if (latCnt_q == 2'd0) begin
                  ldIn_q    <= mem_data;
                  ldField_q <= capField_q;
                  ldNeg_q   <= capNeg_q;
                  ldStart_q <= 1'b1;
                  state_q   <= S_ISSUE;
               end else begin
                  latCnt_q <= latCnt_q - 2'd1;
               end
            end
            S_ISSUE: begin
               ldStart_q <= 1'b0;
               state_q   <= S_HOLD;
            end
            S_HOLD: begin
               if (ld_stop) begin
                  stop_q  <= 1'b1;
                  fault_q <= 1'b0;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               stop_q  <= 1'b0;
               fault_q <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_addr = memAddr_q;
   assign mem_re   = memRe_q;
   assign ld_start = ldStart_q;
   assign ld_in    = ldIn_q;
   assign ld_field = ldField_q;
   assign ld_neg   = ldNeg_q;
   assign stop     = stop_q;
   assign fault    = fault_q;

endmodule

// File: tb/tb_ld_operand_fetch.sv
// Directed bench for ld_operand_fetch: a latency-1 and a latency-3 instance run
// side by side on shared requests, each with its own memory and LD responder.
module tb_ld_operand_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [11:0] address;
   logic [5:0]  field;
   logic        neg;

   logic [11:0] memAddrF, memAddrS;
   logic        memReF, memReS;
   logic [30:0] memDataF, memDataS;
   logic        ldStartF, ldStartS;
   logic [30:0] ldInF, ldInS;
   logic [5:0]  ldFieldF, ldFieldS;
   logic        ldNegF, ldNegS;
   logic        ldStopF, ldStopS;
   logic        stopF, stopS;
   logic        faultF, faultS;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int          reCycle;
      int          reCount;
      logic [11:0] reAddr;
      int          startCycle;
      int          startCount;
      logic [30:0] ldIn;
      logic [5:0]  ldField;
      logic        ldNeg;
      int          stopCycle;
      int          stopCount;
      logic        faultAtStop;
      logic        faultAfter;
   } obs_t;

   ld_operand_fetch #(.MEM_WORDS(4000), .MEM_LATENCY(1)) dutFast (
      .clk(clk), .rst(rst), .start(start), .address(address), .field(field), .neg(neg),
      .mem_addr(memAddrF), .mem_re(memReF), .mem_data(memDataF),
      .ld_start(ldStartF), .ld_in(ldInF), .ld_field(ldFieldF), .ld_neg(ldNegF),
      .ld_stop(ldStopF), .stop(stopF), .fault(faultF)
   );

   ld_operand_fetch #(.MEM_WORDS(4000), .MEM_LATENCY(3)) dutSlow (
      .clk(clk), .rst(rst), .start(start), .address(address), .field(field), .neg(neg),
      .mem_addr(memAddrS), .mem_re(memReS), .mem_data(memDataS),
      .ld_start(ldStartS), .ld_in(ldInS), .ld_field(ldFieldS), .ld_neg(ldNegS),
      .ld_stop(ldStopS), .stop(stopS), .fault(faultS)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Records when each handshake output first fires within one request window.
   task automatic sampleObs(input int c, input logic re, input logic [11:0] ma, input logic ls,
                            input logic [30:0] li, input logic [5:0] lf, input logic ln,
                            input logic st, input logic ft, input obs_t oi, output obs_t oo);
      oo = oi;
      if (re) begin
         if (oo.reCycle < 0) begin
            oo.reCycle = c;
            oo.reAddr  = ma;
         end
         oo.reCount++;
      end
      if (ls) begin
         if (oo.startCycle < 0) begin
            oo.startCycle = c;
            oo.ldIn       = li;
            oo.ldField    = lf;
            oo.ldNeg      = ln;
         end
         oo.startCount++;
      end
      if (oo.stopCycle >= 0 && c == oo.stopCycle + 1 && oo.stopCount == 1)
         oo.faultAfter = ft;
      if (st) begin
         if (oo.stopCycle < 0) begin
            oo.stopCycle   = c;
            oo.faultAtStop = ft;
         end
         oo.stopCount++;
      end
   endtask

   // Issues a request at cycle 0 (extra start pulses at busyA/busyB carry address 200),
   // models memory returning data only in its valid cycle and an LD unit answering one cycle after ld_start.
   task automatic applyStimulus(input logic [11:0] a, input logic [5:0] f, input logic n,
                                input logic [30:0] d, input int busyA, input int busyB,
                                output obs_t oF, output obs_t oS);
      obs_t tF, tS;
      tF = '{default: 0};
      tF.reCycle = -1;
      tF.startCycle = -1;
      tF.stopCycle = -1;
      tS = tF;
      for (int c = 0; c < 16; c++) begin
         start    = (c == 0) || (c == busyA) || (c == busyB);
         address  = (c == 0) ? a : 12'd200;
         field    = f;
         neg      = n;
         memDataF = (tF.reCycle >= 0 && c == tF.reCycle + 1) ? d : ~d;
         memDataS = (tS.reCycle >= 0 && c == tS.reCycle + 3) ? d : ~d;
         ldStopF  = (tF.startCycle >= 0 && c == tF.startCycle + 1);
         ldStopS  = (tS.startCycle >= 0 && c == tS.startCycle + 1);
         sampleObs(c, memReF, memAddrF, ldStartF, ldInF, ldFieldF, ldNegF, stopF, faultF, tF, tF);
         sampleObs(c, memReS, memAddrS, ldStartS, ldInS, ldFieldS, ldNegS, stopS, faultS, tS, tS);
         tick();
      end
      start   = 1'b0;
      ldStopF = 1'b0;
      ldStopS = 1'b0;
      oF = tF;
      oS = tS;
   endtask

   task automatic test_reset();
      int spurious;
      rst = 1'b1;
      tick();
      checks++;
      if ({memAddrF, memReF, ldStartF, ldInF, ldFieldF, ldNegF, stopF, faultF} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_fast: outputs=%h expected 0",
                  {memAddrF, memReF, ldStartF, ldInF, ldFieldF, ldNegF, stopF, faultF});
      end
      checks++;
      if ({memAddrS, memReS, ldStartS, ldInS, ldFieldS, ldNegS, stopS, faultS} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_slow: outputs=%h expected 0",
                  {memAddrS, memReS, ldStartS, ldInS, ldFieldS, ldNegS, stopS, faultS});
      end
      rst = 1'b0;
      tick();

      // Run a valid fetch into HOLD on the fast instance, then reset.
      memDataF = 31'h7123_4567;
      memDataS = 31'h7123_4567;
      start    = 1'b1;
      address  = 12'd100;
      field    = 6'd5;
      neg      = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      checks++;
      if (ldInF !== 31'h7123_4567) begin
         errors++;
         $display("[TB] FAIL reset_precond_ld_in: got %h expected %h", ldInF, 31'h7123_4567);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({memAddrF, memReF, ldStartF, ldInF, ldFieldF, ldNegF, stopF, faultF} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_midhold_fast: outputs=%h expected 0",
                  {memAddrF, memReF, ldStartF, ldInF, ldFieldF, ldNegF, stopF, faultF});
      end
      tick();
      rst = 1'b0;
      ldStopF = 1'b1;
      ldStopS = 1'b1;
      spurious = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         ldStopF = 1'b0;
         ldStopS = 1'b0;
         if (stopF || stopS) spurious++;
      end
      checks++;
      if (spurious !== 0) begin
         errors++;
         $display("[TB] FAIL reset_no_stop: stop pulses=%0d expected 0", spurious);
      end
      checks++;
      if ({memAddrS, memReS, ldStartS, ldInS, ldFieldS, ldNegS, stopS, faultS} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_after_slow: outputs=%h expected 0",
                  {memAddrS, memReS, ldStartS, ldInS, ldFieldS, ldNegS, stopS, faultS});
      end
   endtask

   task automatic test_basic();
      obs_t oF, oS;
      applyStimulus(12'd100, 6'd5, 1'b0, 31'h4000_0041, -1, -1, oF, oS);
      checks++;
      if (oF.reCycle !== 1 || oF.reAddr !== 12'd100 || oF.reCount !== 1) begin
         errors++;
         $display("[TB] FAIL basic_mem_re: cycle=%0d addr=%0d count=%0d expected 1/100/1",
                  oF.reCycle, oF.reAddr, oF.reCount);
      end
      checks++;
      if (oF.startCycle !== 3 || oF.startCount !== 1) begin
         errors++;
         $display("[TB] FAIL basic_ld_start: cycle=%0d count=%0d expected 3/1", oF.startCycle, oF.startCount);
      end
      checks++;
      if (oF.ldIn !== 31'h4000_0041 || oF.ldField !== 6'd5 || oF.ldNeg !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_ld_data: in=%h field=%0d neg=%0b expected 40000041/5/0",
                  oF.ldIn, oF.ldField, oF.ldNeg);
      end
      checks++;
      if (oF.stopCycle !== 5 || oF.faultAtStop !== 1'b0 || oF.stopCount !== 1) begin
         errors++;
         $display("[TB] FAIL basic_stop: cycle=%0d fault=%0b count=%0d expected 5/0/1",
                  oF.stopCycle, oF.faultAtStop, oF.stopCount);
      end
   endtask

   task automatic test_addr_bound();
      obs_t oF, oS;
      applyStimulus(12'd4000, 6'd5, 1'b0, 31'h0000_0fff, -1, -1, oF, oS);
      checks++;
      if (oF.stopCycle !== 1 || oF.faultAtStop !== 1'b1 || oF.faultAfter !== 1'b0) begin
         errors++;
         $display("[TB] FAIL addr4000_fault: stop=%0d fault=%0b after=%0b expected 1/1/0",
                  oF.stopCycle, oF.faultAtStop, oF.faultAfter);
      end
      checks++;
      if (oF.reCount !== 0 || oF.startCount !== 0 || oS.reCount !== 0 || oS.startCount !== 0) begin
         errors++;
         $display("[TB] FAIL addr4000_no_access: re=%0d/%0d ld_start=%0d/%0d expected 0",
                  oF.reCount, oS.reCount, oF.startCount, oS.startCount);
      end
      applyStimulus(12'd3999, 6'd13, 1'b1, 31'h2AAA_5555, -1, -1, oF, oS);
      checks++;
      if (oF.reAddr !== 12'd3999 || oF.ldIn !== 31'h2AAA_5555 || oF.ldField !== 6'd13 ||
          oF.stopCycle !== 5 || oF.faultAtStop !== 1'b0) begin
         errors++;
         $display("[TB] FAIL addr3999_ok: addr=%0d in=%h field=%0d stop=%0d fault=%0b expected 3999/2aaa5555/13/5/0",
                  oF.reAddr, oF.ldIn, oF.ldField, oF.stopCycle, oF.faultAtStop);
      end
   endtask

   task automatic test_field();
      obs_t oF, oS;
      applyStimulus(12'd10, 6'd6, 1'b0, 31'h0000_0001, -1, -1, oF, oS);
      checks++;
      if (oF.stopCycle !== 1 || oF.faultAtStop !== 1'b1 || oF.reCount !== 0) begin
         errors++;
         $display("[TB] FAIL field6_fault: stop=%0d fault=%0b re=%0d expected 1/1/0",
                  oF.stopCycle, oF.faultAtStop, oF.reCount);
      end
      applyStimulus(12'd10, 6'd40, 1'b0, 31'h0000_0001, -1, -1, oF, oS);
      checks++;
      if (oF.stopCycle !== 1 || oF.faultAtStop !== 1'b1 || oF.reCount !== 0) begin
         errors++;
         $display("[TB] FAIL field40_fault: stop=%0d fault=%0b re=%0d expected 1/1/0",
                  oF.stopCycle, oF.faultAtStop, oF.reCount);
      end
      applyStimulus(12'd11, 6'd45, 1'b1, 31'h0155_0aa3, -1, -1, oF, oS);
      checks++;
      if (oF.ldField !== 6'd45 || oF.ldNeg !== 1'b1 || oF.ldIn !== 31'h0155_0aa3 ||
          oF.stopCycle !== 5 || oF.faultAtStop !== 1'b0) begin
         errors++;
         $display("[TB] FAIL field45_ok: field=%0d neg=%0b in=%h stop=%0d fault=%0b expected 45/1/01550aa3/5/0",
                  oF.ldField, oF.ldNeg, oF.ldIn, oF.stopCycle, oF.faultAtStop);
      end
      applyStimulus(12'd0, 6'd0, 1'b0, 31'h4000_0000, -1, -1, oF, oS);
      checks++;
      if (oF.ldField !== 6'd0 || oF.stopCycle !== 5 || oF.faultAtStop !== 1'b0 || oF.reCount !== 1) begin
         errors++;
         $display("[TB] FAIL field0_ok: field=%0d stop=%0d fault=%0b re=%0d expected 0/5/0/1",
                  oF.ldField, oF.stopCycle, oF.faultAtStop, oF.reCount);
      end
   endtask

   task automatic test_latency();
      obs_t oF, oS;
      applyStimulus(12'd50, 6'd13, 1'b0, 31'h1234_5678, -1, -1, oF, oS);
      checks++;
      if (oS.reCycle !== 1 || oS.startCycle !== 5 || oF.startCycle !== 3) begin
         errors++;
         $display("[TB] FAIL latency3_timing: re=%0d ld_start=%0d (fast %0d) expected 1/5/3",
                  oS.reCycle, oS.startCycle, oF.startCycle);
      end
      checks++;
      if (oS.ldIn !== 31'h1234_5678 || oF.ldIn !== 31'h1234_5678) begin
         errors++;
         $display("[TB] FAIL latency_data: slow=%h fast=%h expected 12345678", oS.ldIn, oF.ldIn);
      end
      checks++;
      if (oS.stopCycle !== 7 || oS.faultAtStop !== 1'b0) begin
         errors++;
         $display("[TB] FAIL latency3_stop: cycle=%0d fault=%0b expected 7/0", oS.stopCycle, oS.faultAtStop);
      end
   endtask

   task automatic test_back_to_back();
      obs_t oF, oS;
      applyStimulus(12'd100, 6'd5, 1'b0, 31'h3f00_0001, 2, 5, oF, oS);
      checks++;
      if (oF.stopCount !== 1 || oF.reCount !== 1 || oF.reAddr !== 12'd100) begin
         errors++;
         $display("[TB] FAIL busy_fast: stops=%0d re=%0d addr=%0d expected 1/1/100",
                  oF.stopCount, oF.reCount, oF.reAddr);
      end
      checks++;
      if (oS.stopCount !== 1 || oS.reCount !== 1 || oS.reAddr !== 12'd100) begin
         errors++;
         $display("[TB] FAIL busy_slow: stops=%0d re=%0d addr=%0d expected 1/1/100",
                  oS.stopCount, oS.reCount, oS.reAddr);
      end
      checks++;
      if (memAddrF !== 12'd100 || ldInF !== 31'h3f00_0001) begin
         errors++;
         $display("[TB] FAIL busy_hold: mem_addr=%0d ld_in=%h expected 100/3f000001", memAddrF, ldInF);
      end
      applyStimulus(12'd101, 6'd1, 1'b1, 31'h0000_0abc, -1, -1, oF, oS);
      checks++;
      if (oF.reCycle !== 1 || oF.reAddr !== 12'd101 || oF.ldIn !== 31'h0000_0abc || oF.stopCycle !== 5) begin
         errors++;
         $display("[TB] FAIL next_request: re=%0d addr=%0d in=%h stop=%0d expected 1/101/00000abc/5",
                  oF.reCycle, oF.reAddr, oF.ldIn, oF.stopCycle);
      end
   endtask

   // Scenario sequence.
   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      address  = '0;
      field    = '0;
      neg      = 1'b0;
      memDataF = '0;
      memDataS = '0;
      ldStopF  = 1'b0;
      ldStopS  = 1'b0;
      test_reset();
      test_basic();
      test_addr_bound();
      test_field();
      test_latency();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ld_operand_fetch.md
Name: ld_operand_fetch

Overview:
- Operand-fetch stage for the MIX load instructions LDA, LDX, LD1–LD6 and their negated forms, opcodes 8–23.
- Takes the effective address M, the field spec F and the negate flag from the decoder.
- Checks M and F, reads the memory word, then hands word, F and negate to the LD field-extraction unit.
- Sequences the start/stop handshake with that unit and reports completion or fault to the control unit.

Parameters:
- MEM_WORDS, 4000, number of valid memory words; addresses ≥ MEM_WORDS are faults.
- MEM_LATENCY, 1, cycles from mem_re asserted to mem_data valid (1..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request pulse; ignored unless idle.
- address  in  12  effective address M.
- field  in  6  field spec F = 8L+R; bits [2:0] = R, bits [5:3] = L.
- neg  in  1  1 for LDxN opcodes.
- mem_addr  out  12  memory read address.
- mem_re  out  1  memory read enable.
- mem_data  in  31  memory word: bit 30 = sign, bits 29:0 = bytes 1..5 (6 bits each, byte 1 at 29:24).
- ld_start  out  1  one-cycle start pulse to the LD unit.
- ld_in  out  31  captured memory word.
- ld_field  out  6  captured F.
- ld_neg  out  1  captured neg.
- ld_stop  in  1  completion pulse from the LD unit.
- stop  out  1  one-cycle completion pulse to control.
- fault  out  1  valid with stop: 1 = address or field invalid.

Behaviour:
- All outputs are registered. Reset value of every output and of all state is 0; state = IDLE.
- Reset asserted mid-operation aborts immediately, and no stop is emitted.
- States: IDLE, READ, WAIT, ISSUE, HOLD, DONE.
- IDLE:
  - On start, capture address, field and neg.
  - Compute valid = (address < MEM_WORDS) && (R ≤ 5) && (L ≤ R).
  - If valid → READ; else → DONE with fault=1.
- READ (1 cycle):
  - mem_re=1, mem_addr=captured address.
  - Load latency counter with MEM_LATENCY−1; → WAIT.
- WAIT:
  - mem_re=0; mem_addr holds.
  - Counter 0: capture mem_data into ld_in, → ISSUE. Else decrement.
- ISSUE (1 cycle): ld_start=1; ld_field/ld_neg drive captured values; → HOLD.
- HOLD: wait for ld_stop, then → DONE with fault=0.
  - ld_stop arriving in the ISSUE cycle itself is not possible (LD is 2-cycle) and is ignored.
- DONE (1 cycle): stop=1 with fault as set; → IDLE.
  - fault clears to 0 the cycle after stop.
- Hold rules:
  - ld_in, ld_field and ld_neg stay stable from ISSUE until the next valid fetch captures new data.
  - The LD unit samples them only at ld_start.
- Latency, valid request, MEM_LATENCY=1, LD taking 2 cycles:
  - start in cycle 0.
  - mem_re in cycle 1.
  - data captured at end of cycle 2.
  - ld_start in cycle 3.
  - ld_stop in cycle 4.
  - stop in cycle 5.
- Fault latency: start in cycle 0 → stop+fault in cycle 1. No mem_re, no ld_start.
- Busy handling: start while not IDLE is ignored entirely. Start in the same cycle as the DONE pulse is also ignored; a new request needs IDLE.
- F=0 (0:0) is valid: sign only. F=5 (0:5) is valid. F=13 (1:5) is valid. F=6 and F=40 (5:0) are faults.

Decomposition:
- Shared package holds:
  - MEM_WORDS default.
  - Field-bit slice positions: R=[2:0], L=[5:3].
  - Word layout constants: sign bit 30, byte width 6.
  - State encoding.
- One natural sub-module: field_check, a combinational L/R/address validity check, reusable by the store and compare fetch stages.

Test Plan:
- Reset: mid-HOLD, then release → stop never pulses; all outputs 0.
- address=100, F=5, neg=0, mem_data=31'h4000_0041, MEM_LATENCY=1:
  - mem_re in cycle 1 with mem_addr=100.
  - ld_start in cycle 3 with ld_in=31'h4000_0041, ld_field=5, ld_neg=0.
  - stop in cycle 5 with fault=0, given ld_stop driven in cycle 4.
- address=4000, F=5 → stop+fault=1 in cycle 1; mem_re and ld_start never asserted. Repeat with address=3999 → normal fetch.
- F=6, F=40, F=45 (5:5) → first two fault. F=45 passes with ld_field=45, ld_neg=1 when neg=1.
- MEM_LATENCY=3 → ld_start exactly 2 cycles later than the latency-1 case; ld_in matches the data presented 3 cycles after mem_re.
- start pulsed again during WAIT and in the DONE cycle → ignored: one stop per accepted request, captured address unchanged.
